// File: rtl/tdc_sar.sv
// Successive-approximation TDC controller: drives a binary-weighted delay line MSB-first,
// samples an edge arbiter once per bit, and optionally averages 2^AVG_LOG2 passes.
module tdc_sar #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SETTLE   = 3,
  parameter int unsigned AVG_LOG2 = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             arb_i,
  output logic [WIDTH-1:0] dly_code_o,
  output logic             fire_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] out_o
);

  localparam int unsigned IDX_W     = $clog2(WIDTH);
  localparam int unsigned CNT_W     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned ACC_W     = WIDTH + AVG_LOG2;
  localparam int unsigned PASS_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned LAST_PASS = (1 << AVG_LOG2) - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRE,
    S_WAIT,
    S_DECIDE,
    S_DONE
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   code_q;
  logic [WIDTH-1:0]   dly_q;
  logic [WIDTH-1:0]   out_q;
  logic               fire_q;
  logic               busy_q;
  logic               valid_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ACC_W-1:0]   acc_q;
  logic [PASS_W-1:0]  pass_q;

  logic [WIDTH-1:0]   trial_d;
  logic [WIDTH-1:0]   decided_d;
  logic [ACC_W-1:0]   acc_d;
  logic               pass_last_d;

  // Trial keeps the decided upper bits and sets the bit under test; the arbiter keeps or drops it.
  always_comb begin
    trial_d     = code_q | (WIDTH'(1) << idx_q);
    decided_d   = arb_i ? dly_q : code_q;
    acc_d       = acc_q + ACC_W'(decided_d);
    pass_last_d = (pass_q == PASS_W'(LAST_PASS));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      dly_q   <= '0;
      out_q   <= '0;
      fire_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      idx_q   <= IDX_W'(WIDTH - 1);
      cnt_q   <= '0;
      acc_q   <= '0;
      pass_q  <= '0;
    end else begin
      fire_q  <= 1'b0;
      valid_q <= 1'b0;
      if (abort_i && (state_q != S_IDLE)) begin
        // Cancel drops all partial work; out_q keeps the last published result.
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        dly_q   <= '0;
        code_q  <= '0;
        acc_q   <= '0;
        pass_q  <= '0;
        idx_q   <= IDX_W'(WIDTH - 1);
        cnt_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            dly_q <= '0;
            if (start_i && !abort_i) begin
              state_q <= S_FIRE;
              busy_q  <= 1'b1;
            end else begin
              busy_q <= 1'b0;
            end
          end
          S_FIRE: begin
            dly_q   <= trial_d;
            fire_q  <= 1'b1;
            cnt_q   <= CNT_W'(SETTLE - 1);
            state_q <= S_WAIT;
          end
          S_WAIT: begin
            if (cnt_q == '0) begin
              state_q <= S_DECIDE;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          S_DECIDE: begin
            if (idx_q == '0) begin
              acc_q  <= acc_d;
              code_q <= '0;
              idx_q  <= IDX_W'(WIDTH - 1);
              if (pass_last_d) begin
                pass_q  <= '0;
                dly_q   <= '0;
                state_q <= S_DONE;
              end else begin
                pass_q  <= pass_q + PASS_W'(1);
                state_q <= S_FIRE;
              end
            end else begin
              code_q  <= decided_d;
              idx_q   <= idx_q - IDX_W'(1);
              state_q <= S_FIRE;
            end
          end
          S_DONE: begin
            out_q   <= WIDTH'(acc_q >> AVG_LOG2);
            acc_q   <= '0;
            valid_q <= 1'b1;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign dly_code_o = dly_q;
  assign fire_o     = fire_q;
  assign busy_o     = busy_q;
  assign valid_o    = valid_q;
  assign out_o      = out_q;

endmodule

// File: tb/tb_tdc_sar.sv
// Bench for tdc_sar: a default instance and an AVG_LOG2=2 instance driven by an ideal
// arbiter (T >= trial code, latched while fire is high).
module tb_tdc_sar;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_d, abort_d;
  logic       arb_d = 1'b0;
  logic [7:0] dly_code_d, out_d;
  logic       fire_d, busy_d, valid_d;

  logic       start_a, abort_a;
  logic       arb_a = 1'b0;
  logic [7:0] dly_code_a, out_a;
  logic       fire_a, busy_a, valid_a;

  int vec = 0;
  int err = 0;

  logic [7:0] t_d = 8'h00;
  logic [7:0] t_avg [4];
  int         fire_cnt_a = 0;

  tdc_sar #(.WIDTH(8), .SETTLE(3), .AVG_LOG2(0)) u_dut_d (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_d), .abort_i(abort_d), .arb_i(arb_d),
    .dly_code_o(dly_code_d), .fire_o(fire_d), .busy_o(busy_d), .valid_o(valid_d), .out_o(out_d)
  );

  tdc_sar #(.WIDTH(8), .SETTLE(3), .AVG_LOG2(2)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .abort_i(abort_a), .arb_i(arb_a),
    .dly_code_o(dly_code_a), .fire_o(fire_a), .busy_o(busy_a), .valid_o(valid_a), .out_o(out_a)
  );

  // Ideal arbiters: decision for the code currently launched, held until the next fire.
  always @(negedge clk) if (fire_d === 1'b1) arb_d = (t_d >= dly_code_d);

  always @(negedge clk) begin
    if (fire_a === 1'b1) begin
      arb_a = (t_avg[(fire_cnt_a / 8) % 4] >= dly_code_a);
      fire_cnt_a = (fire_cnt_a + 1) % 32;
    end
  end

  // Binary search toward T: the trial for bit i is T's bits above i with bit i set.
  function automatic logic [7:0] exp_trial(input logic [7:0] t, input int i);
    int unsigned tv;
    tv = 32'(t);
    return 8'(((tv >> (i + 1)) << (i + 1)) | (32'd1 << i));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One default-instance measurement; optional one-cycle start pulse at edge pulse_e.
  task automatic run_d(input logic [7:0] t, input int pulse_e, input string tag);
    int n_fire = 0;
    int edge_v = -1;
    t_d = t;
    @(negedge clk); start_d = 1'b1;
    @(posedge clk); #1; start_d = 1'b0;
    chk({tag, "/busy_on"}, 32'(busy_d), 32'd1);
    for (int e = 1; e <= 60 && edge_v < 0; e++) begin
      start_d = (e == pulse_e);
      @(posedge clk); #1;
      if (fire_d === 1'b1) begin
        chk({tag, "/fire_edge"}, 32'(e), 32'(1 + 5 * n_fire));
        if (n_fire < 8) chk({tag, "/trial"}, 32'(dly_code_d), 32'(exp_trial(t, 7 - n_fire)));
        n_fire++;
      end
      if (valid_d === 1'b1) begin
        edge_v = e;
        chk({tag, "/out"}, 32'(out_d), 32'(t));
      end
    end
    start_d = 1'b0;
    chk({tag, "/valid_edge"}, 32'(edge_v), 32'd41);
    chk({tag, "/n_fire"}, 32'(n_fire), 32'd8);
    @(posedge clk); #1;
    chk({tag, "/busy_off"}, 32'(busy_d), 32'd0);
    chk({tag, "/valid_off"}, 32'(valid_d), 32'd0);
  endtask

  // One averaging-instance measurement over four passes with the given interval values.
  task automatic run_a(input logic [7:0] t0, t1, t2, t3, input string tag);
    int n_fire = 0;
    int edge_v = -1;
    int n_valid = 0;
    int unsigned sum;
    t_avg[0] = t0; t_avg[1] = t1; t_avg[2] = t2; t_avg[3] = t3;
    sum = 32'(t0) + 32'(t1) + 32'(t2) + 32'(t3);
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    for (int e = 1; e <= 200 && edge_v < 0; e++) begin
      @(posedge clk); #1;
      if (fire_a === 1'b1) begin
        chk({tag, "/fire_edge"}, 32'(e), 32'(1 + 5 * n_fire));
        if (n_fire < 32)
          chk({tag, "/trial"}, 32'(dly_code_a), 32'(exp_trial(t_avg[n_fire / 8], 7 - (n_fire % 8))));
        n_fire++;
      end
      if (valid_a === 1'b1) begin
        edge_v = e;
        chk({tag, "/out"}, 32'(out_a), sum >> 2);
      end
    end
    chk({tag, "/valid_edge"}, 32'(edge_v), 32'd161);
    chk({tag, "/n_fire"}, 32'(n_fire), 32'd32);
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      if (valid_a === 1'b1) n_valid++;
    end
    chk({tag, "/extra_valid"}, 32'(n_valid), 32'd0);
    chk({tag, "/busy_off"}, 32'(busy_a), 32'd0);
  endtask

  initial begin
    int n_fire;
    int n_valid;
    int v0;
    int v1;
    logic [7:0] tr;

    rst_n = 1'b0;
    start_d = 1'b0; abort_d = 1'b0;
    start_a = 1'b0; abort_a = 1'b0;
    t_avg[0] = 8'd0; t_avg[1] = 8'd0; t_avg[2] = 8'd0; t_avg[3] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/dly_code", 32'(dly_code_d), 32'd0);
    chk("rst/fire", 32'(fire_d), 32'd0);
    chk("rst/busy", 32'(busy_d), 32'd0);
    chk("rst/valid", 32'(valid_d), 32'd0);
    chk("rst/out", 32'(out_d), 32'd0);
    chk("rst/out_avg", 32'(out_a), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_d(8'hA5, -1, "dflt_a5");
    run_d(8'h00, -1, "ext_00");
    run_d(8'hFF, -1, "ext_ff");
    for (int k = 0; k < 4; k++) run_d(8'($urandom_range(0, 255)), -1, "rand");

    run_a(8'd100, 8'd101, 8'd102, 8'd103, "avg_fixed");
    run_a(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "avg_rand");

    // Abort at edge 15 after a completed 0xA5 measurement.
    run_d(8'hA5, -1, "pre_abort");
    @(negedge clk); start_d = 1'b1;
    @(posedge clk); #1; start_d = 1'b0;
    for (int e = 1; e <= 14; e++) @(posedge clk);
    @(negedge clk); abort_d = 1'b1;
    @(posedge clk); #1; abort_d = 1'b0;
    chk("abort/busy", 32'(busy_d), 32'd0);
    chk("abort/fire", 32'(fire_d), 32'd0);
    chk("abort/dly_code", 32'(dly_code_d), 32'd0);
    n_fire = 0; n_valid = 0;
    for (int e = 0; e < 60; e++) begin
      @(posedge clk); #1;
      if (fire_d === 1'b1) n_fire++;
      if (valid_d === 1'b1) n_valid++;
    end
    chk("abort/no_fire", 32'(n_fire), 32'd0);
    chk("abort/no_valid", 32'(n_valid), 32'd0);
    chk("abort/out_kept", 32'(out_d), 32'hA5);
    run_d(8'($urandom_range(0, 255)), -1, "post_abort");

    // Start pulse while busy must be ignored.
    run_d(8'h5A, 10, "pulse_busy");
    n_valid = 0;
    for (int e = 0; e < 50; e++) begin
      @(posedge clk); #1;
      if (valid_d === 1'b1) n_valid++;
    end
    chk("pulse_busy/extra_valid", 32'(n_valid), 32'd0);

    // Start held high: back-to-back measurements.
    t_d = 8'h3C;
    v0 = -1; v1 = -1;
    @(negedge clk); start_d = 1'b1;
    for (int e = 0; e <= 90; e++) begin
      @(posedge clk); #1;
      if (valid_d === 1'b1) begin
        chk("held/out", 32'(out_d), 32'h3C);
        if (v0 < 0) v0 = e;
        else if (v1 < 0) v1 = e;
      end
    end
    chk("held/valid0_edge", 32'(v0), 32'd41);
    chk("held/valid_spacing", 32'(v1 - v0), 32'd42);
    @(negedge clk); start_d = 1'b0; abort_d = 1'b1;
    @(posedge clk); #1; abort_d = 1'b0;
    chk("held/abort_busy", 32'(busy_d), 32'd0);

    // start and abort together in IDLE.
    @(negedge clk); start_d = 1'b1; abort_d = 1'b1;
    @(posedge clk); #1;
    chk("start_abort/busy", 32'(busy_d), 32'd0);
    @(negedge clk); start_d = 1'b0; abort_d = 1'b0;
    n_fire = 0;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk); #1;
      if (fire_d === 1'b1) n_fire++;
    end
    chk("start_abort/no_fire", 32'(n_fire), 32'd0);

    // Asynchronous reset in the middle of a conversion.
    t_d = 8'h77;
    @(negedge clk); start_d = 1'b1;
    @(posedge clk); #1; start_d = 1'b0;
    for (int e = 1; e <= 20; e++) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid/dly_code", 32'(dly_code_d), 32'd0);
    chk("rst_mid/fire", 32'(fire_d), 32'd0);
    chk("rst_mid/busy", 32'(busy_d), 32'd0);
    chk("rst_mid/valid", 32'(valid_d), 32'd0);
    chk("rst_mid/out", 32'(out_d), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tr = 8'($urandom_range(1, 255));
    run_d(tr, -1, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/tdc_sar.md
# tdc_sar

Parametrised successive-approximation time-to-digital converter controller. It is the clocked, width-generic successor of the fixed 8/32-bit cascaded TDCs. It resolves WIDTH bits MSB-first by driving an external binary-weighted programmable delay line and sampling an external edge arbiter once per bit. It also adds optional power-of-two conversion averaging and an abort path. It sits between the measurement sequencer (start/result handshake) and the analog delay-line/arbiter macro.

## Interface
- WIDTH, 8, result and delay-code width in bits (≥ 2)
- SETTLE, 3, cycles waited after each fire before sampling the arbiter (≥ 1)
- AVG_LOG2, 0, log2 of conversions averaged per result (0 = no averaging)
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous active-low reset
- start  input  1  request a measurement; accepted only in IDLE
- abort  input  1  synchronous cancel; highest priority after rst
- arb  input  1  arbiter decision for the last fire: 1 = true interval ≥ trial code
- dly_code  output  WIDTH  trial code applied to the delay line
- fire  output  1  one-cycle pulse launching one start/stop edge pair
- busy  output  1  high from the cycle after acceptance until valid or abort
- valid  output  1  one-cycle pulse; out updated in the same cycle
- out  output  WIDTH  averaged result; held until the next valid

## Operation
- Reset values: dly_code=0, fire=0, busy=0, valid=0, out=0. All internal state is cleared and the FSM enters IDLE.
- States and transitions:
  - IDLE → FIRE when start=1.
  - FIRE (1 cycle) → WAIT.
  - WAIT (SETTLE cycles, down-counter) → DECIDE.
  - DECIDE (1 cycle) → FIRE if bits remain, or if bits are done and passes remain; otherwise → DONE.
  - DONE (1 cycle, valid=1) → IDLE.
- Per bit i, from WIDTH-1 down to 0:
  - In FIRE: trial = decided bits | (1<<i). dly_code=trial, fire=1.
  - dly_code holds trial through WAIT and DECIDE.
  - In DECIDE: bit i is kept if arb=1, cleared if arb=0. arb is sampled only in DECIDE.
- Pass end: the WIDTH-bit code is added to the accumulator. The accumulator is WIDTH+AVG_LOG2 bits wide and cannot overflow. The code register clears, the bit index reloads to WIDTH-1, and the pass counter increments.
- After 2^AVG_LOG2 passes, DONE loads out = accumulator >> AVG_LOG2 (truncation, no rounding), then the accumulator clears.
- dly_code returns to 0 in DONE and stays 0 in IDLE.
- start is ignored outside IDLE, with no queuing. start held high in IDLE at the DONE→IDLE return begins a new measurement on the next edge.
- abort=1 in any non-IDLE state returns to IDLE on that edge:
  - fire, busy and dly_code go to 0.
  - The accumulator, pass counter and code register clear.
  - No valid is generated; out keeps its previous value.
  - abort in IDLE has no effect. abort and start together in IDLE: abort wins and the measurement is not accepted.
- rst low mid-conversion: immediate return to reset values, including out=0.

## Timing
- Edge 0 accepts start. FIRE occupies the cycle after edge 0; busy=1 from edge 0 onward.
- One bit takes SETTLE+2 cycles. One pass takes WIDTH·(SETTLE+2) cycles.
- L = 2^AVG_LOG2 · WIDTH · (SETTLE+2). valid and the new out are registered at edge L+1. busy falls at edge L+2, together with valid.
- Defaults (8, 3, 0): fire pulses at edges 1, 6, 11, …, 36; valid is high at edge 41.
- Minimum start-to-start spacing: L+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Defaults. Bench arbiter model arb = (T ≥ dly_code) latched at fire, T=0xA5. Required: 8 fire pulses; dly_code sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5; out=0xA5 with valid at edge 41.
- Extremes. T=0 → out=0x00. T=0xFF → out=0xFF; the last trial is 0xFF. Each case is a separate start.
- Averaging, AVG_LOG2=2. T = 100, 101, 102, 103 on successive passes. Required: 32 fires; out=101 (406>>2); valid at edge 161; single valid pulse.
- Abort. abort at edge 15 of a default run: busy=0 and fire=0 from edge 15; no valid; out keeps its prior 0xA5. A fresh start then gives the correct result.
- Handshake corners:
  - start pulsed during busy → ignored, one valid only.
  - start held high → back-to-back measurements, valids 42 cycles apart.
  - start+abort in IDLE → not accepted.
- Reset mid-run. rst low at edge 20 → all outputs 0 asynchronously, FSM in IDLE. After release, start gives a correct result.
